// File: rtl/ysyx_22051013_trap_ctrl_pkg.sv
// rtl/ysyx_22051013_trap_ctrl_pkg.sv - shared encodings for the CSR/trap sequencer
// Contents: FSM state and request-kind encodings, machine CSR addresses,
// mstatus bit positions, csr_ctl bit indices, csr_op codes, cause codes.
package ysyx_22051013_trap_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CS_RD,
        ST_CS_WR,
        ST_FIN,
        ST_EC_MEPC,
        ST_EC_MCAUSE,
        ST_EC_STAT,
        ST_MR_RD,
        ST_MR_EPC,
        ST_MR_STAT
    } state_e;

    typedef enum logic [1:0] {
        K_CSR,
        K_ECALL,
        K_MRET
    } kind_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // csr_ctl = {wr, rd, ecall, mret}
    localparam int CTL_WR    = 3;
    localparam int CTL_RD    = 2;
    localparam int CTL_ECALL = 1;
    localparam int CTL_MRET  = 0;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam int CAUSE_ILLEGAL = 2;

    function automatic logic csr_supported(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
               (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/ysyx_22051013_csr_alu.sv
// rtl/ysyx_22051013_csr_alu.sv - combinational CSR value and mstatus update logic
// Ports: op/old_val/src -> csr_new (RW/RS/RC result);
//        mstatus -> mstatus_trap (trap entry), mstatus_ret (MRET).
module ysyx_22051013_csr_alu
    import ysyx_22051013_trap_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] src,
    input  logic [XLEN-1:0] mstatus,
    output logic [XLEN-1:0] csr_new,
    output logic [XLEN-1:0] mstatus_trap,
    output logic [XLEN-1:0] mstatus_ret
);

    always_comb begin
        case (op)
            OP_RW:   csr_new = src;
            OP_RS:   csr_new = old_val | src;
            OP_RC:   csr_new = old_val & ~src;
            default: csr_new = old_val;
        endcase

        mstatus_trap                                = mstatus;
        mstatus_trap[MSTATUS_MPIE]                  = mstatus[MSTATUS_MIE];
        mstatus_trap[MSTATUS_MIE]                   = 1'b0;
        mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

        mstatus_ret                                 = mstatus;
        mstatus_ret[MSTATUS_MIE]                    = mstatus[MSTATUS_MPIE];
        mstatus_ret[MSTATUS_MPIE]                   = 1'b1;
        mstatus_ret[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    end

endmodule

// File: rtl/ysyx_22051013_trap_ctrl.sv
// rtl/ysyx_22051013_trap_ctrl.sv - multi-cycle sequencer for CSR access, ECALL and MRET
// Ports: request (req_valid, csr_ctl, csr_op, csr_addr, src, pc, rd_addr_i),
//        front-end control (stall_o, done_o, redirect_o, redirect_pc),
//        writeback (rd_we, rd_addr, rd_wdata), 1R1W CSR file port (csr_re/raddr/rdata,
//        csr_we/waddr/wdata). Optional macro YSYX_22051013_CSR_CHK_EN turns accesses to
//        unimplemented CSRs into an illegal-instruction trap.
module ysyx_22051013_trap_ctrl
    import ysyx_22051013_trap_ctrl_pkg::*;
#(
    parameter int XLEN         = 64,
    parameter int MCAUSE_ECALL = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [3:0]      csr_ctl,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] src,
    input  logic [XLEN-1:0] pc,
    input  logic [4:0]      rd_addr_i,
    output logic            stall_o,
    output logic            done_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_wdata,
    output logic            csr_re,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata
);

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d, kind_in;
    logic            wr_q, wr_d, rd_q, rd_d;
    logic [1:0]      op_q, op_d;
    logic [11:0]     addr_q, addr_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] src_q, src_d, pc_q, pc_d;
    logic [XLEN-1:0] old_q, old_d, mstat_q, mstat_d, target_q, target_d;
    logic [XLEN-1:0] cause, mstat_sel, alu_new, alu_trap, alu_ret;

`ifdef YSYX_22051013_CSR_CHK_EN
    logic illegal_q, illegal_d, illegal_in;
    assign illegal_in = (kind_in == K_CSR) && !csr_supported(csr_addr);
    assign cause      = illegal_q ? XLEN'(CAUSE_ILLEGAL) : XLEN'(MCAUSE_ECALL);
`else
    assign cause      = XLEN'(MCAUSE_ECALL);
`endif

    always_comb begin
        if (csr_ctl[CTL_ECALL])     kind_in = K_ECALL;
        else if (csr_ctl[CTL_MRET]) kind_in = K_MRET;
        else                        kind_in = K_CSR;
    end

    // MRET updates mstatus straight from the read port; ECALL uses the copy latched a cycle earlier.
    assign mstat_sel = (state_q == ST_MR_STAT) ? csr_rdata : mstat_q;

    ysyx_22051013_csr_alu #(.XLEN(XLEN)) u_alu (
        .op           (op_q),
        .old_val      (csr_rdata),
        .src          (src_q),
        .mstatus      (mstat_sel),
        .csr_new      (alu_new),
        .mstatus_trap (alu_trap),
        .mstatus_ret  (alu_ret)
    );

    // Gated by rst so every output reads 0 while reset is held.
    assign stall_o = rst & req_valid & (state_q != ST_FIN) &
                     ((state_q != ST_IDLE) | (csr_ctl != 4'b0));

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        op_d        = op_q;
        addr_d      = addr_q;
        rd_addr_d   = rd_addr_q;
        src_d       = src_q;
        pc_d        = pc_q;
        old_d       = old_q;
        mstat_d     = mstat_q;
        target_d    = target_q;
`ifdef YSYX_22051013_CSR_CHK_EN
        illegal_d   = illegal_q;
`endif
        done_o      = 1'b0;
        redirect_o  = 1'b0;
        redirect_pc = '0;
        rd_we       = 1'b0;
        rd_addr     = '0;
        rd_wdata    = '0;
        csr_re      = 1'b0;
        csr_raddr   = '0;
        csr_we      = 1'b0;
        csr_waddr   = '0;
        csr_wdata   = '0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && (csr_ctl != 4'b0)) begin
                    wr_d      = csr_ctl[CTL_WR];
                    rd_d      = csr_ctl[CTL_RD];
                    op_d      = csr_op;
                    addr_d    = csr_addr;
                    rd_addr_d = rd_addr_i;
                    src_d     = src;
                    pc_d      = pc;
                    kind_d    = kind_in;
`ifdef YSYX_22051013_CSR_CHK_EN
                    illegal_d = illegal_in;
                    if (illegal_in) kind_d = K_ECALL;
`endif
                    case (kind_d)
                        K_ECALL: state_d = ST_EC_MEPC;
                        K_MRET:  state_d = ST_MR_RD;
                        default: state_d = ST_CS_RD;
                    endcase
                end
            end
            ST_CS_RD: begin
                csr_re    = 1'b1;
                csr_raddr = addr_q;
                state_d   = ST_CS_WR;
            end
            ST_CS_WR: begin
                old_d     = csr_rdata;
                csr_we    = wr_q;
                csr_waddr = wr_q ? addr_q : 12'h0;
                csr_wdata = wr_q ? alu_new : '0;
                state_d   = ST_FIN;
            end
            ST_EC_MEPC: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MEPC;
                csr_wdata = pc_q;
                csr_re    = 1'b1;
                csr_raddr = CSR_MSTATUS;
                state_d   = ST_EC_MCAUSE;
            end
            ST_EC_MCAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MCAUSE;
                csr_wdata = cause;
                mstat_d   = csr_rdata;
                csr_re    = 1'b1;
                csr_raddr = CSR_MTVEC;
                state_d   = ST_EC_STAT;
            end
            ST_EC_STAT: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = alu_trap;
                // Direct mode only: the mtvec MODE field is dropped.
                target_d  = {csr_rdata[XLEN-1:2], 2'b00};
                state_d   = ST_FIN;
            end
            ST_MR_RD: begin
                csr_re    = 1'b1;
                csr_raddr = CSR_MEPC;
                state_d   = ST_MR_EPC;
            end
            ST_MR_EPC: begin
                target_d  = csr_rdata;
                csr_re    = 1'b1;
                csr_raddr = CSR_MSTATUS;
                state_d   = ST_MR_STAT;
            end
            ST_MR_STAT: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = alu_ret;
                state_d   = ST_FIN;
            end
            ST_FIN: begin
                done_o = 1'b1;
                if (kind_q != K_CSR) begin
                    redirect_o  = 1'b1;
                    redirect_pc = target_q;
                end else begin
                    rd_we    = rd_q && (rd_addr_q != 5'd0);
                    rd_addr  = rd_addr_q;
                    rd_wdata = old_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            kind_q    <= K_CSR;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            op_q      <= '0;
            addr_q    <= '0;
            rd_addr_q <= '0;
            src_q     <= '0;
            pc_q      <= '0;
            old_q     <= '0;
            mstat_q   <= '0;
            target_q  <= '0;
`ifdef YSYX_22051013_CSR_CHK_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            rd_addr_q <= rd_addr_d;
            src_q     <= src_d;
            pc_q      <= pc_d;
            old_q     <= old_d;
            mstat_q   <= mstat_d;
            target_q  <= target_d;
`ifdef YSYX_22051013_CSR_CHK_EN
            illegal_q <= illegal_d;
`endif
        end
    end

endmodule
